// File: rtl/prim_sweep.sv
// prim_sweep: walks codes 0..15 through the numPrim detector,
// counting primes and tracking the largest prime seen.
module prim_sweep #(
   parameter int HOLD = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   input  logic       prime_in,
   output logic       busy,
   output logic       done,
   output logic [4:0] prime_cnt,
   output logic [3:0] last_prime
);

   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_n;
   logic [3:0]      code;
   logic [3:0]      code_n;
   logic [HW-1:0]   hold_cnt;
   logic [HW-1:0]   hold_n;
   logic [4:0]      cnt_n;
   logic [3:0]      last_n;

   assign {a, b, c, d} = code;

   // next-state and datapath updates for the sweep sequencer
   always_comb begin
      state_n = state;
      code_n  = code;
      hold_n  = hold_cnt;
      cnt_n   = prime_cnt;
      last_n  = last_prime;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               state_n = RUN;
               code_n  = 4'd0;
               hold_n  = '0;
               cnt_n   = 5'd0;
               last_n  = 4'd0;
            end else begin
               state_n = IDLE;
            end
         end
         RUN: begin
            if (abort) begin
               state_n = IDLE;
            end else if (hold_cnt != HOLD_LAST) begin
               hold_n = hold_cnt + 1'b1;
            end else begin
               if (prime_in) begin
                  cnt_n  = prime_cnt + 5'd1;
                  last_n = code;
               end
               if (code == 4'd15) begin
                  state_n = DONE;
               end else begin
                  code_n = code + 4'd1;
                  hold_n = '0;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // state, datapath and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         code       <= 4'd0;
         hold_cnt   <= '0;
         prime_cnt  <= 5'd0;
         last_prime <= 4'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         code       <= code_n;
         hold_cnt   <= hold_n;
         prime_cnt  <= cnt_n;
         last_prime <= last_n;
         busy       <= (state_n == RUN);
         done       <= (state_n == DONE);
      end
   end

endmodule

// File: tb/tb_prim_sweep.sv
// tb_prim_sweep: directed bench for prim_sweep with HOLD=1 and HOLD=3,
// numPrim modelled in the bench, results checked via a scoreboard.
module tb_prim_sweep;

   typedef struct {
      logic [4:0] cnt;
      logic [3:0] last;
   } res_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start1, abort1, start3, abort3;
   logic       a1, b1, c1, d1, busy1, done1, p1;
   logic       a3, b3, c3, d3, busy3, done3, p3;
   logic [4:0] cnt1, cnt3;
   logic [3:0] last1, last3;
   logic       force_en, force_val;

   int   total;
   int   passed;
   res_t sbq[$];

   function automatic logic is_prime(input logic [3:0] v);
      case (v)
         4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // expected result of sampling codes 0..n-1
   function automatic res_t model(input logic fe, input logic fv,
                                  input int n);
      res_t r;
      logic p;
      r.cnt  = 5'd0;
      r.last = 4'd0;
      for (int v = 0; v < n; v++) begin
         p = fe ? fv : is_prime(4'(v));
         if (p) begin
            r.cnt  = r.cnt + 5'd1;
            r.last = 4'(v);
         end
      end
      return r;
   endfunction

   assign p1 = force_en ? force_val : is_prime({a1, b1, c1, d1});
   assign p3 = is_prime({a3, b3, c3, d3});

   prim_sweep #(.HOLD(1)) u1 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort1),
      .a(a1), .b(b1), .c(c1), .d(d1), .prime_in(p1),
      .busy(busy1), .done(done1), .prime_cnt(cnt1),
      .last_prime(last1)
   );

   prim_sweep #(.HOLD(3)) u3 (
      .clk(clk), .rst(rst), .start(start3), .abort(abort3),
      .a(a3), .b(b3), .c(c3), .d(d3), .prime_in(p3),
      .busy(busy3), .done(done3), .prime_cnt(cnt3),
      .last_prime(last3)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input bit s3);
      if (s3) start3 = 1'b1;
      else start1 = 1'b1;
      step();
      start1 = 1'b0;
      start3 = 1'b0;
   endtask

   task automatic wait_done(input bit s3, input int lim,
                            inout int cyc);
      while (!(s3 ? done3 : done1) && cyc < lim) begin
         step();
         cyc++;
      end
      chk("done_seen", {31'd0, (s3 ? done3 : done1)}, 32'd1);
   endtask

   task automatic check_result(input bit s3, input string tag);
      res_t e;
      if (sbq.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sbq.pop_front();
         chk({tag, "_cnt"}, {27'd0, (s3 ? cnt3 : cnt1)},
             {27'd0, e.cnt});
         chk({tag, "_last"}, {28'd0, (s3 ? last3 : last1)},
             {28'd0, e.last});
      end
   endtask

   initial begin
      int   cyc;
      res_t e;
      total     = 0;
      passed    = 0;
      rst       = 1'b1;
      start1    = 1'b0;
      abort1    = 1'b0;
      start3    = 1'b0;
      abort3    = 1'b0;
      force_en  = 1'b0;
      force_val = 1'b0;
      step();
      step();

      chk("rst_code", {28'd0, a1, b1, c1, d1}, 32'd0);
      chk("rst_busy", {31'd0, busy1}, 32'd0);
      chk("rst_done", {31'd0, done1}, 32'd0);
      chk("rst_cnt", {27'd0, cnt1}, 32'd0);
      chk("rst_last", {28'd0, last1}, 32'd0);
      chk("rst_busy3", {31'd0, busy3}, 32'd0);
      rst = 1'b0;
      step();

      // full sweep, HOLD=1, real detector
      sbq.push_back(model(1'b0, 1'b0, 16));
      pulse_start(1'b0);
      cyc = 1;
      chk("h1_busy", {31'd0, busy1}, 32'd1);
      chk("h1_code0", {28'd0, a1, b1, c1, d1}, 32'd0);
      for (int k = 1; k < 16; k++) begin
         step();
         cyc++;
         chk("h1_code", {28'd0, a1, b1, c1, d1}, 32'(k));
      end
      wait_done(1'b0, 200, cyc);
      chk("h1_latency", 32'(cyc), 32'd17);
      chk("h1_busy_end", {31'd0, busy1}, 32'd0);
      check_result(1'b0, "h1");
      step();
      chk("h1_done_pulse", {31'd0, done1}, 32'd0);
      chk("h1_cnt_stable", {27'd0, cnt1}, 32'd6);
      chk("h1_code_hold", {28'd0, a1, b1, c1, d1}, 32'd15);

      // full sweep, HOLD=3
      sbq.push_back(model(1'b0, 1'b0, 16));
      pulse_start(1'b1);
      cyc = 1;
      chk("h3_code_e0", {28'd0, a3, b3, c3, d3}, 32'd0);
      step();
      cyc++;
      chk("h3_code_e1", {28'd0, a3, b3, c3, d3}, 32'd0);
      step();
      cyc++;
      chk("h3_code_e2", {28'd0, a3, b3, c3, d3}, 32'd0);
      step();
      cyc++;
      chk("h3_code_e3", {28'd0, a3, b3, c3, d3}, 32'd1);
      wait_done(1'b1, 400, cyc);
      chk("h3_latency", 32'(cyc), 32'd49);
      check_result(1'b1, "h3");
      step();

      // forced prime_in = 1 then 0
      force_en  = 1'b1;
      force_val = 1'b1;
      sbq.push_back(model(1'b1, 1'b1, 16));
      pulse_start(1'b0);
      cyc = 1;
      wait_done(1'b0, 200, cyc);
      check_result(1'b0, "force1");
      step();
      force_val = 1'b0;
      sbq.push_back(model(1'b1, 1'b0, 16));
      pulse_start(1'b0);
      cyc = 1;
      wait_done(1'b0, 200, cyc);
      check_result(1'b0, "force0");
      force_en = 1'b0;
      step();

      // start during RUN ignored, then abort at code 6
      pulse_start(1'b0);
      step();
      step();
      step();
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      chk("ab_no_restart", {28'd0, a1, b1, c1, d1}, 32'd4);
      step();
      step();
      chk("ab_code6", {28'd0, a1, b1, c1, d1}, 32'd6);
      abort1 = 1'b1;
      step();
      abort1 = 1'b0;
      e = model(1'b0, 1'b0, 6);
      chk("ab_busy", {31'd0, busy1}, 32'd0);
      chk("ab_done", {31'd0, done1}, 32'd0);
      chk("ab_cnt", {27'd0, cnt1}, {27'd0, e.cnt});
      chk("ab_last", {28'd0, last1}, {28'd0, e.last});
      step();
      chk("ab_done_late", {31'd0, done1}, 32'd0);
      chk("ab_cnt_keep", {27'd0, cnt1}, {27'd0, e.cnt});

      // back-to-back sweeps
      sbq.push_back(model(1'b0, 1'b0, 16));
      pulse_start(1'b0);
      cyc = 1;
      wait_done(1'b0, 200, cyc);
      check_result(1'b0, "b2b_first");
      sbq.push_back(model(1'b0, 1'b0, 16));
      pulse_start(1'b0);
      cyc = 1;
      chk("b2b_busy", {31'd0, busy1}, 32'd1);
      chk("b2b_cnt_clr", {27'd0, cnt1}, 32'd0);
      chk("b2b_last_clr", {28'd0, last1}, 32'd0);
      chk("b2b_code0", {28'd0, a1, b1, c1, d1}, 32'd0);
      chk("b2b_done_low", {31'd0, done1}, 32'd0);
      wait_done(1'b0, 200, cyc);
      chk("b2b_latency", 32'(cyc), 32'd17);
      check_result(1'b0, "b2b_second");
      step();

      // reset mid-sweep at code 7
      pulse_start(1'b0);
      for (int k = 0; k < 7; k++) step();
      chk("mr_code7", {28'd0, a1, b1, c1, d1}, 32'd7);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mr_code", {28'd0, a1, b1, c1, d1}, 32'd0);
      chk("mr_busy", {31'd0, busy1}, 32'd0);
      chk("mr_done", {31'd0, done1}, 32'd0);
      chk("mr_cnt", {27'd0, cnt1}, 32'd0);
      chk("mr_last", {28'd0, last1}, 32'd0);
      step();
      chk("mr_idle", {31'd0, busy1}, 32'd0);
      sbq.push_back(model(1'b0, 1'b0, 16));
      pulse_start(1'b0);
      cyc = 1;
      chk("mr_restart0", {28'd0, a1, b1, c1, d1}, 32'd0);
      step();
      cyc++;
      chk("mr_restart1", {28'd0, a1, b1, c1, d1}, 32'd1);
      wait_done(1'b0, 200, cyc);
      check_result(1'b0, "mr_sweep");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/prim_sweep.md
# prim_sweep

Sweep sequencer and result collector for the `numPrim` prime detector.
- On a start pulse it drives the detector's four inputs `a`, `b`, `c`, `d` through every code from 0 to 15 in ascending order.
- It samples the detector's `out` for each code, counting primes and recording the largest prime found.
- It flags completion with a one-cycle `done` pulse.
- It sits in front of `numPrim`, which is combinational, and closes the loop back from `numPrim`'s output.

## Interface
- `HOLD`, default 1: cycles each code is held on `a..d` before `prime_in` is sampled. Legal range ≥1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a sweep. Honoured only in IDLE or DONE.
- `abort`  in  1  terminates a sweep in RUN; ignored otherwise.
- `a`  out  1  code bit 3 (MSB), registered.
- `b`  out  1  code bit 2, registered.
- `c`  out  1  code bit 1, registered.
- `d`  out  1  code bit 0 (LSB), registered.
- `prime_in`  in  1  `numPrim` `out` for the code currently on `a..d`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse at the end of a completed sweep.
- `prime_cnt`  out  5  number of codes sampled prime in the current or last sweep (0..16).
- `last_prime`  out  4  highest code sampled prime in the current or last sweep; 0 if none.

## Operation
- The state machine has three states: IDLE, RUN and DONE.
- Internal registers:
  - `code[3:0]`, driving `{a,b,c,d}`.
  - `hold_cnt`, width clog2(HOLD), minimum 1 bit.
- IDLE:
  - `start`=1 → RUN.
  - On that transition: `code`=0, `hold_cnt`=0, `prime_cnt`=0, `last_prime`=0.
- RUN, each cycle:
  - If `abort`=1 → IDLE. No sample is taken that cycle, `done` stays 0, and `prime_cnt`/`last_prime` keep their partial values.
  - Else if `hold_cnt`≠HOLD−1: `hold_cnt`++.
  - Else: sample `prime_in`. If it is 1, then `prime_cnt`++ and `last_prime`=`code`.
    - If `code`=15 → DONE.
    - Otherwise `code`++ and `hold_cnt`=0.
- DONE:
  - `done`=1 for exactly this cycle, then → IDLE.
  - `start` in DONE behaves as in IDLE, i.e. the next state is RUN with the same clearing.
- `start` during RUN is ignored.
- `abort` and `start` together in IDLE: `start` wins.
- `code` is never incremented past 15, so it does not wrap; it holds 15 after a completed sweep.
- `prime_cnt` cannot overflow (maximum 16 fits in 5 bits).
- Because ascending order is fixed, `last_prime` is simply the most recent prime sample.

## Timing
- Reset values: state IDLE, `a`=`b`=`c`=`d`=0, `busy`=0, `done`=0, `prime_cnt`=0, `last_prime`=0, `hold_cnt`=0.
- `rst` takes priority over all inputs and returns the block to reset values on the next edge, including mid-sweep.
- All outputs are registered.
- `prime_in` is treated as valid in the same cycle as the registered code because `numPrim` is combinational; no extra pipeline stage.
- `start` sampled at edge E0:
  - `busy`=1 and code 0 are visible from E0.
  - Code k is presented for HOLD cycles, beginning at E0+k·HOLD.
  - Sample of code k is taken at edge E0+(k+1)·HOLD.
  - `done`=1 during the cycle after edge E0+16·HOLD.
  - `busy`=0 from that same edge.
- Total start-to-done latency: 16·HOLD+1 cycles.
- `prime_cnt` and `last_prime` update at each sampling edge and are stable from the `done` cycle until the next accepted `start`.

## Test plan
- Reset mid-sweep (HOLD=1): assert `rst` at code 7 → next cycle all outputs at reset values; state IDLE; a subsequent `start` begins from code 0.
- Full sweep, HOLD=1, real `numPrim` attached: pulse `start` → `a..d` step 0..15 on consecutive cycles; `done` pulses exactly 17 cycles after `start`; `prime_cnt`=6; `last_prime`=13 (binary 1101).
- Full sweep, HOLD=3: each code held 3 cycles; `done` 49 cycles after `start`; `prime_cnt`=6; `last_prime`=13.
- Forced `prime_in`: tie `prime_in`=1 → `prime_cnt`=16, `last_prime`=15. Tie `prime_in`=0 → `prime_cnt`=0, `last_prime`=0.
- Abort at code 6 (HOLD=1): → IDLE, no `done` pulse, `prime_cnt`=3 (codes 2, 3, 5), `last_prime`=5. A `start` during RUN before the abort is ignored, and the sequence does not restart.
- Back-to-back: `start` asserted in the DONE cycle → new sweep begins immediately; `prime_cnt` cleared to 0 on the RUN entry edge.
